prbs7_link_test_ctrl: RTL

Sequences a PRBS7 word generator for link self-test and checks the words returned over the serial loopback. The block drives the generator's disable, seed-load and seed inputs, self-synchronises a local PRBS7 checker to the received word stream, and declares lock. Once locked, it counts word errors and, optionally, bit errors. It sits in the readout test path between slow control and the generator/serializer pair.

---
 rtl/prbs7_pkg.sv | 46 ++++
 rtl/prbs7_word_checker.sv | 63 ++++++
 rtl/prbs7_link_test_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/prbs7_pkg.sv
// PRBS7 link-test shared definitions: FSM state encoding, PRBS7 taps and
// the word-generation function shared by the checker. Optional feature
// macro used by the files importing this package: PRBS7_BITERR_EN.
package prbs7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_SYNC   = 2'd2,
        ST_LOCKED = 2'd3
    } prbs7_state_e;

    // Feedback taps of x^7 + x^6 + 1 as seen from the shift register
    localparam int PRBS7_TAP_LO = 0;
    localparam int PRBS7_TAP_HI = 1;

    // Widest word the generation function supports
    localparam int PRBS7_MAX_WIDTH = 64;

    typedef struct packed {
        logic [6:0]                 next;
        logic [PRBS7_MAX_WIDTH-1:0] word;
    } prbs7_word_t;

    // Runs the recurrence width times from state; bit 0 of word is the
    // first bit in time, next is the register after the last bit.
    function automatic prbs7_word_t prbs7_word(input logic [6:0] state, input int width);
        prbs7_word_t r;
        logic [6:0]  s;
        logic        b;
        s      = state;
        r.word = '0;
        for (int i = 0; i < PRBS7_MAX_WIDTH; i++) begin
            if (i < width) begin
                b         = s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO];
                r.word[i] = b;
                s         = {b, s[6:1]};
            end else begin
                r.word[i] = 1'b0;
            end
        end
        r.next = s;
        return r;
    endfunction

endpackage

// File: rtl/prbs7_word_checker.sv
// PRBS7 word checker: holds the local checker state, produces the expected
// word, flags a mismatch against the received word and, when
// PRBS7_BITERR_EN is defined, counts the differing bits.
module prbs7_word_checker
    import prbs7_pkg::*;
#(
    parameter int WORDWIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load,
    input  logic                           advance,
    input  logic [WORDWIDTH-1:0]           rx_word,
    output logic                           mismatch
`ifdef PRBS7_BITERR_EN
    ,
    output logic [$clog2(WORDWIDTH+1)-1:0] bit_errs
`endif
);

    localparam int PW = $clog2(WORDWIDTH + 1);

    logic [6:0]           chk_state_r;
    prbs7_word_t          exp_s;
    logic [WORDWIDTH-1:0] exp_word_s;
    logic                 unused_s;

    assign exp_s      = prbs7_word(chk_state_r, WORDWIDTH);
    assign exp_word_s = exp_s.word[WORDWIDTH-1:0];
    assign unused_s   = ^exp_s.word;
    assign mismatch   = (rx_word != exp_word_s);

    // Checker state: resync from the received word, or free-run from the expected word
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_state_r <= '0;
        end else if (load) begin
            chk_state_r <= rx_word[WORDWIDTH-1 -: 7];
        end else if (advance) begin
            chk_state_r <= exp_s.next;
        end else begin
            chk_state_r <= chk_state_r;
        end
    end

`ifdef PRBS7_BITERR_EN
    logic [WORDWIDTH-1:0] diff_s;
    logic [PW-1:0]        pop_s;

    assign diff_s = rx_word ^ exp_word_s;

    // Population count of the differing bits in this word
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            pop_s = pop_s + PW'(diff_s[i]);
        end
    end

    assign bit_errs = pop_s;
`endif

endmodule

// File: rtl/prbs7_link_test_ctrl.sv
// PRBS7 link self-test controller: sequences the word generator (disable,
// seed load), self-synchronises the local checker, declares lock and counts
// errors while locked. Define PRBS7_BITERR_EN to build the bit-error counter;
// otherwise bit_err_cnt is tied to zero.
module prbs7_link_test_ctrl
    import prbs7_pkg::*;
#(
    parameter int WORDWIDTH    = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clr_cnt,
    input  logic [6:0]           seed,
    output logic                 gen_dis,
    output logic                 gen_load_n,
    output logic [6:0]           gen_seed,
    input  logic [WORDWIDTH-1:0] rx_word,
    input  logic                 rx_valid,
    output logic                 locked,
    output logic                 lock_lost,
    output logic [CNT_WIDTH-1:0] word_err_cnt,
    output logic [CNT_WIDTH-1:0] bit_err_cnt
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] UNLOCK_LAST = EW'(UNLOCK_COUNT - 1);

    prbs7_state_e   state_r, next_s;
    logic           first_r;
    logic [MW-1:0]  match_cnt_r;
    logic [EW-1:0]  err_run_r;
    logic           gen_dis_r, gen_load_n_r, locked_r, lock_lost_r;
    logic [6:0]     gen_seed_r;
    logic [CNT_WIDTH-1:0] word_err_r;
    logic           mismatch_s, chk_load_s, chk_adv_s, err_inc_s;

    assign chk_load_s = (state_r == ST_SYNC) && rx_valid;
    assign chk_adv_s  = (state_r == ST_LOCKED) && rx_valid;
    assign err_inc_s  = chk_adv_s && mismatch_s;

`ifdef PRBS7_BITERR_EN
    localparam int PW = $clog2(WORDWIDTH + 1);
    localparam int SW = CNT_WIDTH + PW;
    logic [PW-1:0]        bit_errs_s;
    logic [SW-1:0]        bit_sum_s;
    logic [CNT_WIDTH-1:0] bit_err_r;

    prbs7_word_checker #(.WORDWIDTH(WORDWIDTH)) u_checker (
        .clk      (clk),
        .reset    (reset),
        .load     (chk_load_s),
        .advance  (chk_adv_s),
        .rx_word  (rx_word),
        .mismatch (mismatch_s),
        .bit_errs (bit_errs_s)
    );

    assign bit_sum_s = SW'(bit_err_r) + SW'(bit_errs_s);

    // Bit-error counter: clear wins, saturates at all-ones
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            bit_err_r <= '0;
        end else if (err_inc_s) begin
            if (bit_sum_s > SW'({CNT_WIDTH{1'b1}})) begin
                bit_err_r <= '1;
            end else begin
                bit_err_r <= bit_sum_s[CNT_WIDTH-1:0];
            end
        end else begin
            bit_err_r <= bit_err_r;
        end
    end

    assign bit_err_cnt = bit_err_r;
`else
    prbs7_word_checker #(.WORDWIDTH(WORDWIDTH)) u_checker (
        .clk      (clk),
        .reset    (reset),
        .load     (chk_load_s),
        .advance  (chk_adv_s),
        .rx_word  (rx_word),
        .mismatch (mismatch_s)
    );

    assign bit_err_cnt = '0;
`endif

    // Next-state logic; stop overrides every other transition
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_SEED;
                else       next_s = ST_IDLE;
            end
            ST_SEED: begin
                next_s = ST_SYNC;
            end
            ST_SYNC: begin
                if (rx_valid && !first_r && !mismatch_s && (match_cnt_r == LOCK_LAST)) next_s = ST_LOCKED;
                else next_s = ST_SYNC;
            end
            ST_LOCKED: begin
                if (rx_valid && mismatch_s && (err_run_r == UNLOCK_LAST)) next_s = ST_SYNC;
                else next_s = ST_LOCKED;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
        if (stop) begin
            next_s = ST_IDLE;
        end else begin
            next_s = next_s;
        end
    end

    // State register and registered generator/lock outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            gen_dis_r    <= 1'b1;
            gen_load_n_r <= 1'b1;
            locked_r     <= 1'b0;
            gen_seed_r   <= 7'd0;
        end else begin
            state_r      <= next_s;
            gen_dis_r    <= (next_s == ST_IDLE);
            gen_load_n_r <= (next_s != ST_SEED);
            locked_r     <= (next_s == ST_LOCKED);
            gen_seed_r   <= ((state_r == ST_IDLE) && start && !stop) ? seed : gen_seed_r;
        end
    end

    // Sync bookkeeping: load-only flag for the first word and consecutive-match count
    always_ff @(posedge clk) begin
        if (reset) begin
            first_r     <= 1'b0;
            match_cnt_r <= '0;
        end else begin
            if ((next_s == ST_SYNC) && (state_r != ST_SYNC)) first_r <= 1'b1;
            else if (chk_load_s)                             first_r <= 1'b0;
            else                                             first_r <= first_r;

            if (state_r != ST_SYNC)         match_cnt_r <= '0;
            else if (chk_load_s && !first_r) match_cnt_r <= mismatch_s ? '0 : match_cnt_r + 1'b1;
            else                            match_cnt_r <= match_cnt_r;
        end
    end

    // Consecutive-error run length while locked
    always_ff @(posedge clk) begin
        if (reset || (state_r != ST_LOCKED)) begin
            err_run_r <= '0;
        end else if (chk_adv_s) begin
            if (mismatch_s && (err_run_r != UNLOCK_LAST)) err_run_r <= err_run_r + 1'b1;
            else                                         err_run_r <= '0;
        end else begin
            err_run_r <= err_run_r;
        end
    end

    // Word-error counter and sticky lock-lost flag; clear wins over updates
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            word_err_r  <= '0;
            lock_lost_r <= 1'b0;
        end else begin
            if (err_inc_s && (word_err_r != {CNT_WIDTH{1'b1}})) word_err_r <= word_err_r + 1'b1;
            else                                                 word_err_r <= word_err_r;

            if ((state_r == ST_LOCKED) && (next_s == ST_SYNC)) lock_lost_r <= 1'b1;
            else                                                lock_lost_r <= lock_lost_r;
        end
    end

    assign gen_dis      = gen_dis_r;
    assign gen_load_n   = gen_load_n_r;
    assign gen_seed     = gen_seed_r;
    assign locked       = locked_r;
    assign lock_lost    = lock_lost_r;
    assign word_err_cnt = word_err_r;

endmodule
